// File: rtl/uart_alu_ctrl.sv
// Sequences UART bytes into ALU operands/opcode, launches the result back out
// through the transmitter, and flags timeouts, illegal opcodes and overruns.
module uart_alu_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_error,
  output logic               o_overrun
);

  localparam int NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;

  logic [2:0]        state;
  logic [NB_CNT-1:0] timeout_count;
  logic              op_legal;
  logic              timeout_hit;

  always_comb begin
    op_legal = 1'b0;
    case (i_rx_data[NB_OP-1:0])
      NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
      NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b000011),
      NB_OP'(6'b000010), NB_OP'(6'b100111): op_legal = 1'b1;
      default:                              op_legal = 1'b0;
    endcase
  end

  assign o_busy      = (state == ST_EXEC) || (state == ST_SEND) || (state == ST_WAIT_TX);
  assign timeout_hit = (timeout_count == CNT_MAX);

  // A byte arriving on the timeout cycle wins over the timeout because rx_valid is tested first.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= ST_WAIT_A;
      timeout_count <= '0;
      o_data_a      <= '0;
      o_data_b      <= '0;
      o_op          <= '0;
      o_tx_data     <= '0;
      o_tx_start    <= 1'b0;
      o_error       <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_error    <= 1'b0;
      o_overrun  <= i_rx_valid && o_busy;
      case (state)
        ST_WAIT_A: begin
          timeout_count <= '0;
          if (i_rx_valid) begin
            o_data_a <= i_rx_data;
            state    <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (i_rx_valid) begin
            o_data_b      <= i_rx_data;
            timeout_count <= '0;
            state         <= ST_WAIT_OP;
          end else if (timeout_hit) begin
            o_error       <= 1'b1;
            timeout_count <= '0;
            state         <= ST_WAIT_A;
          end else begin
            timeout_count <= timeout_count + 1'b1;
          end
        end
        ST_WAIT_OP: begin
          if (i_rx_valid) begin
            timeout_count <= '0;
            if (op_legal) begin
              o_op  <= i_rx_data[NB_OP-1:0];
              state <= ST_EXEC;
            end else begin
              o_error <= 1'b1;
              state   <= ST_WAIT_A;
            end
          end else if (timeout_hit) begin
            o_error       <= 1'b1;
            timeout_count <= '0;
            state         <= ST_WAIT_A;
          end else begin
            timeout_count <= timeout_count + 1'b1;
          end
        end
        ST_EXEC: begin
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          state <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (i_tx_done) begin
            state <= ST_WAIT_A;
          end
        end
        default: begin
          timeout_count <= '0;
          state         <= ST_WAIT_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Randomized self-checking bench for uart_alu_ctrl: a transaction-level model
// tracks operands, opcode and result and checks pulses at their fixed cycles.
module tb_uart_alu_ctrl;

  localparam int T = 16;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_rx_data = '0;
  logic       i_rx_valid = 1'b0;
  logic [7:0] i_alu_result;
  logic       i_tx_done = 1'b0;
  logic [7:0] o_data_a, o_data_b, o_tx_data;
  logic [5:0] o_op;
  logic       o_tx_start, o_busy, o_error, o_overrun;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [7:0] expA = '0, expB = '0, expTx = '0;
  logic [5:0] expOp = '0;

  uart_alu_ctrl #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(T)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid), .i_alu_result(i_alu_result), .i_tx_done(i_tx_done),
    .o_data_a(o_data_a), .o_data_b(o_data_b), .o_op(o_op), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_busy(o_busy), .o_error(o_error), .o_overrun(o_overrun)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [7:0] aluRef(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b000011: return 8'($signed(a) >>> b);
      6'b000010: return a >> b;
      6'b100111: return ~(a | b);
      default:   return 8'h00;
    endcase
  endfunction

  function automatic bit isLegal(input logic [5:0] op);
    logic [5:0] legal [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b100110, 6'b000011, 6'b000010, 6'b100111};
    foreach (legal[i]) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // The ALU sits outside the controller, so the bench supplies it.
  always_comb i_alu_result = aluRef(o_data_a, o_data_b, o_op);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sendByte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    step();
    i_rx_valid = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_a"}, o_data_a, 0);
    checkOutput({tag, "_b"}, o_data_b, 0);
    checkOutput({tag, "_op"}, o_op, 0);
    checkOutput({tag, "_txd"}, o_tx_data, 0);
    checkOutput({tag, "_start"}, o_tx_start, 0);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_err"}, o_error, 0);
    checkOutput({tag, "_ovr"}, o_overrun, 0);
  endtask

  // Full three-byte exchange; gaps below T never time out, a gap of T-1 lands on the timeout cycle.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opByte,
                               input int gapAB, input int gapBOp, input bit doOverrun);
    sendByte(a);
    expA = a;
    idle(gapAB);
    checkOutput("no_err_wait_b", o_error, 0);
    sendByte(b);
    expB = b;
    checkOutput("no_err_after_b", o_error, 0);
    checkOutput("data_a", o_data_a, expA);
    checkOutput("data_b", o_data_b, expB);
    idle(gapBOp);
    sendByte(opByte);
    if (isLegal(opByte[5:0])) begin
      expOp = opByte[5:0];
      expTx = aluRef(expA, expB, expOp);
      checkOutput("op", o_op, expOp);
      checkOutput("busy_exec", o_busy, 1);
      checkOutput("start_early", o_tx_start, 0);
      step();
      checkOutput("tx_start", o_tx_start, 1);
      checkOutput("tx_data", o_tx_data, expTx);
      step();
      checkOutput("start_once", o_tx_start, 0);
      checkOutput("busy_wait_tx", o_busy, 1);
      if (doOverrun) begin
        sendByte($urandom);
        checkOutput("overrun", o_overrun, 1);
        checkOutput("tx_data_kept", o_tx_data, expTx);
        checkOutput("busy_kept", o_busy, 1);
        step();
        checkOutput("overrun_once", o_overrun, 0);
      end
      idle($urandom_range(0, 3));
      checkOutput("busy_before_done", o_busy, 1);
      i_tx_done = 1'b1;
      step();
      i_tx_done = 1'b0;
      checkOutput("idle_after_done", o_busy, 0);
    end else begin
      checkOutput("illegal_err", o_error, 1);
      checkOutput("illegal_op_kept", o_op, expOp);
      checkOutput("illegal_busy", o_busy, 0);
      step();
      checkOutput("illegal_err_once", o_error, 0);
      checkOutput("illegal_no_start", o_tx_start, 0);
    end
  endtask

  task automatic timeoutAfterA(input logic [7:0] a);
    sendByte(a);
    expA = a;
    idle(T - 1);
    checkOutput("timeout_early", o_error, 0);
    step();
    checkOutput("timeout_err", o_error, 1);
    checkOutput("timeout_a_kept", o_data_a, expA);
    checkOutput("timeout_b_kept", o_data_b, expB);
    step();
    checkOutput("timeout_err_once", o_error, 0);
    checkOutput("timeout_busy", o_busy, 0);
  endtask

  initial begin
    logic [7:0] opTable [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
    i_reset = 1'b1;
    idle(2);
    checkAllZero("reset");
    i_reset = 1'b0;

    applyStimulus(8'h05, 8'h03, 8'h20, 0, 0, 1'b0);
    checkOutput("add_result", o_tx_data, 8'h08);
    applyStimulus(8'h05, 8'h03, 8'h3F, 0, 0, 1'b0);
    checkOutput("illegal_op_still_add", o_op, 6'b100000);
    timeoutAfterA(8'hAA);
    applyStimulus(8'h01, 8'h02, 8'h24, 0, 0, 1'b1);
    checkOutput("and_result", o_tx_data, 8'h00);
    applyStimulus(8'h81, 8'h02, 8'h03, T - 1, T - 1, 1'b0);

    sendByte(8'h11);
    sendByte(8'h22);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    expA = '0; expB = '0; expOp = '0; expTx = '0;
    checkAllZero("mid_reset");
    applyStimulus(8'h0F, 8'h01, 8'h02, 1, 1, 1'b0);
    checkOutput("srl_result", o_tx_data, 8'h07);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] opByte;
      opByte = ($urandom_range(0, 3) != 0) ? {2'($urandom), opTable[$urandom_range(0, 7)][5:0]}
                                           : 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        checkOutput("stray_done", o_busy, 0);
      end
      if ($urandom_range(0, 6) == 0) timeoutAfterA(8'($urandom));
      applyStimulus(8'($urandom), 8'($urandom), opByte, $urandom_range(0, T - 1),
                    $urandom_range(0, T - 1), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

Interface
REQ-001 SHALL have parameter NB_DATA, default 8: width of operands, result and UART bytes.
REQ-002 SHALL have parameter NB_OP, default 6: opcode width, taken from bits [NB_OP-1:0] of the opcode byte.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum number of idle clocks allowed between operand/opcode bytes.
REQ-004 SHALL have port i_clock, input, 1: system clock; all logic is on its rising edge.
REQ-005 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port i_rx_data, input, NB_DATA: received byte, valid while i_rx_valid is high.
REQ-007 SHALL have port i_rx_valid, input, 1: single-cycle pulse from the UART receiver.
REQ-008 SHALL have port i_alu_result, input, NB_DATA: combinational ALU result for o_data_a, o_data_b and o_op.
REQ-009 SHALL have port i_tx_done, input, 1: single-cycle pulse from the UART transmitter at the end of its stop bit.
REQ-010 SHALL have port o_data_a, output, NB_DATA: registered operand A to the ALU.
REQ-011 SHALL have port o_data_b, output, NB_DATA: registered operand B to the ALU.
REQ-012 SHALL have port o_op, output, NB_OP: registered opcode to the ALU.
REQ-013 SHALL have port o_tx_data, output, NB_DATA: registered result byte to the transmitter.
REQ-014 SHALL have port o_tx_start, output, 1: single-cycle transmit request.
REQ-015 SHALL have port o_busy, output, 1: high in states EXEC, SEND and WAIT_TX.
REQ-016 SHALL have port o_error, output, 1: single-cycle pulse on timeout or on an illegal opcode.
REQ-017 SHALL have port o_overrun, output, 1: single-cycle pulse when i_rx_valid arrives while o_busy is high.

Function
REQ-018 SHALL implement an FSM with states WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND and WAIT_TX.
REQ-019 In WAIT_A, i_rx_valid SHALL load o_data_a <= i_rx_data and move to WAIT_B.
REQ-020 In WAIT_B, i_rx_valid SHALL load o_data_b <= i_rx_data and move to WAIT_OP.
REQ-021 In WAIT_OP, i_rx_valid with a legal opcode SHALL load o_op and move to EXEC.
- Legal opcodes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 000011 SRA, 000010 SRL, 100111 NOR.
REQ-022 In WAIT_OP, i_rx_valid with an illegal opcode SHALL leave o_op unchanged, pulse o_error for one cycle and return to WAIT_A.
REQ-023 EXEC SHALL last exactly one cycle; at its end o_tx_data <= i_alu_result and the FSM moves to SEND.
REQ-024 SEND SHALL assert o_tx_start for exactly one cycle and then move to WAIT_TX.
REQ-025 WAIT_TX SHALL hold until i_tx_done, then return to WAIT_A.
REQ-026 Latency SHALL be fixed: opcode i_rx_valid accepted in cycle N gives o_tx_start high in cycle N+2, with o_tx_data already valid in that cycle.
REQ-027 A timeout counter SHALL clear on every accepted byte and increment each clock in WAIT_B and WAIT_OP.
- When the counter reaches TIMEOUT_CYCLES-1 with no i_rx_valid, the FSM SHALL return to WAIT_A and pulse o_error.
- The counter width SHALL be $clog2(TIMEOUT_CYCLES) and it SHALL never wrap.
REQ-028 If i_rx_valid coincides with the timeout cycle, the byte SHALL be accepted and no timeout SHALL occur.
REQ-029 i_rx_valid in EXEC, SEND or WAIT_TX SHALL be dropped, pulse o_overrun, and leave all registers and the state unchanged.
REQ-030 i_tx_done outside WAIT_TX SHALL be ignored.
REQ-031 o_data_a, o_data_b and o_op SHALL hold their values between transactions and SHALL NOT clear on timeout or error.
REQ-032 Any unreachable state encoding SHALL go to WAIT_A on the next clock.

Reset
REQ-033 With i_reset high at a clock edge:
- state SHALL become WAIT_A;
- all output registers and the timeout counter SHALL become 0;
- o_tx_start, o_error and o_overrun SHALL be 0.
REQ-034 Reset SHALL take effect in any state, including mid-transaction and in WAIT_TX, and SHALL discard all partial operands.

Verification
REQ-035 Send bytes 0x05, 0x03, 0x20 -> o_op=100000, o_tx_start pulses 2 cycles after the third byte, o_tx_data=0x08 (ALU model), then a later i_tx_done returns the FSM to WAIT_A.
REQ-036 Send 0x05, 0x03, 0x3F -> o_error pulses once, no o_tx_start, o_op unchanged, FSM back in WAIT_A.
REQ-037 Send 0xAA, then nothing for TIMEOUT_CYCLES (set to 16) -> o_error pulses, and a following 0x01, 0x02, 0x24 yields o_tx_data=0x00.
REQ-038 i_rx_valid during WAIT_TX -> o_overrun pulses once, o_tx_data and state are unchanged.
REQ-039 i_rx_valid exactly on the timeout cycle in WAIT_B -> byte loaded into o_data_b, no o_error.
REQ-040 Assert i_reset in WAIT_OP -> all outputs are 0, and a full 3-byte transaction afterwards completes normally.
